// File: rtl/bitwise_logic_seq.sv
// Multi-cycle bitwise logic unit (AND/OR/XOR/NOR), SLICE bits per cycle, start/result-ready handshake.
// Optional flag outputs (data_zero, data_parity) are built when BLU_FLAGS_EN is defined.
module bitwise_logic_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy
`ifdef BLU_FLAGS_EN
    ,
    output logic             data_zero,
    output logic             data_parity
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_lat;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;

    function automatic logic [SLICE-1:0] slice_op(input logic [1:0]       op,
                                                  input logic [SLICE-1:0] a,
                                                  input logic [SLICE-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Working value with the current slice merged in; completion loads this directly
    // so the final slice does not cost an extra cycle.
    always_comb begin
        work_next = work;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                work_next[i*SLICE +: SLICE] = slice_op(op_lat,
                                                       a_lat[i*SLICE +: SLICE],
                                                       b_lat[i*SLICE +: SLICE]);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            op_lat         <= '0;
            a_lat          <= '0;
            b_lat          <= '0;
            work           <= '0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef BLU_FLAGS_EN
            data_zero      <= 1'b0;
            data_parity    <= 1'b0;
`endif
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        op_lat <= opcode;
                        a_lat  <= data_operandA;
                        b_lat  <= data_operandB;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    work <= work_next;
                    if (cnt == LAST) begin
                        cnt            <= '0;
                        data_result    <= work_next;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
`ifdef BLU_FLAGS_EN
                        data_zero      <= ~|work_next;
                        data_parity    <= ^work_next;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_logic_seq.sv
// Self-checking bench for bitwise_logic_seq: three instances (SLICE 8, 32, 1) sharing operands,
// table-driven vectors, hand-written reset/back-to-back sequences and randomized ops vs a word-level model.
module tb_bitwise_logic_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start8 = 1'b0, start32 = 1'b0, start1 = 1'b0;
    logic [1:0]  opcode = 2'b00;
    logic [31:0] opa = '0, opb = '0;

    logic [31:0] res8, res32, res1;
    logic        rdy8, rdy32, rdy1;
    logic        busy8, busy32, busy1;
`ifdef BLU_FLAGS_EN
    logic        z8, p8, z32, p32, z1, p1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    bitwise_logic_seq #(.WIDTH(32), .SLICE(8)) dut8 (
        .clock(clock), .reset(reset), .ctrl_start(start8), .opcode(opcode),
        .data_operandA(opa), .data_operandB(opb),
        .data_result(res8), .data_resultRDY(rdy8), .busy(busy8)
`ifdef BLU_FLAGS_EN
        , .data_zero(z8), .data_parity(p8)
`endif
    );

    bitwise_logic_seq #(.WIDTH(32), .SLICE(32)) dut32 (
        .clock(clock), .reset(reset), .ctrl_start(start32), .opcode(opcode),
        .data_operandA(opa), .data_operandB(opb),
        .data_result(res32), .data_resultRDY(rdy32), .busy(busy32)
`ifdef BLU_FLAGS_EN
        , .data_zero(z32), .data_parity(p32)
`endif
    );

    bitwise_logic_seq #(.WIDTH(32), .SLICE(1)) dut1 (
        .clock(clock), .reset(reset), .ctrl_start(start1), .opcode(opcode),
        .data_operandA(opa), .data_operandB(opb),
        .data_result(res1), .data_resultRDY(rdy1), .busy(busy1)
`ifdef BLU_FLAGS_EN
        , .data_zero(z1), .data_parity(p1)
`endif
    );

    // Word-level reference: the whole result at once, independent of slicing.
    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic [31:0] res_of(input int w);
        case (w)
            0:       return res8;
            1:       return res32;
            default: return res1;
        endcase
    endfunction

    function automatic logic rdy_of(input int w);
        case (w)
            0:       return rdy8;
            1:       return rdy32;
            default: return rdy1;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            0:       return busy8;
            1:       return busy32;
            default: return busy1;
        endcase
    endfunction

`ifdef BLU_FLAGS_EN
    function automatic logic [1:0] flags_of(input int w);
        case (w)
            0:       return {z8, p8};
            1:       return {z32, p32};
            default: return {z1, p1};
        endcase
    endfunction
`endif

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       start8 = v;
            1:       start32 = v;
            default: start1 = v;
        endcase
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Starts an op on instance w from the current cycle and waits for its pulse.
    // With scramble set, inputs and ctrl_start are disturbed on every BUSY cycle.
    task automatic do_op(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input string name, input bit scramble);
        logic [31:0] prev, exp;
        int          cyc;
        bit          held;
        exp    = ref_op(op, a, b);
        opcode = op;
        opa    = a;
        opb    = b;
        set_start(w, 1'b1);
        step();
        set_start(w, 1'b0);
        prev = res_of(w);
        held = 1'b1;
        cyc  = 0;
        while (!rdy_of(w) && cyc < 100) begin
            if (busy_of(w) !== 1'b1 || res_of(w) !== prev) held = 1'b0;
            if (scramble) begin
                opa    = $urandom;
                opb    = $urandom;
                opcode = 2'($urandom_range(0, 3));
                set_start(w, 1'($urandom_range(0, 1)));
            end
            step();
            cyc++;
        end
        set_start(w, 1'b0);
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " hold/busy"}, {31'd0, held}, 32'd1);
        check({name, " result"}, res_of(w), exp);
        check({name, " busy_low"}, {31'd0, busy_of(w)}, 32'd0);
`ifdef BLU_FLAGS_EN
        check({name, " flags"}, {30'd0, flags_of(w)}, {30'd0, (exp == 32'd0), ^exp});
`endif
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          scr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        int          w, lat;
        bit          seen;

        vecs[0] = '{2'd0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0};
        vecs[1] = '{2'd1, 32'h00000001, 32'h80000000, 32'h80000001, 1'b1};
        vecs[2] = '{2'd3, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{2'd2, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0};
        vecs[4] = '{2'd0, 32'h00000001, 32'h00000003, 32'h00000001, 1'b0};
        vecs[5] = '{2'd0, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1};

        // Reset held with start requested: everything stays cleared
        start8 = 1'b1;
        repeat (3) step();
        check("reset result", res8, 32'd0);
        check("reset rdy_busy", {30'd0, rdy8, busy8}, 32'd0);
        reset  = 1'b0;
        start8 = 1'b0;
        repeat (5) step();
        check("idle result", res8, 32'd0);
        check("idle rdy_busy", {30'd0, rdy8, busy8}, 32'd0);
`ifdef BLU_FLAGS_EN
        check("idle flags", {30'd0, z8, p8}, 32'd0);
`endif

        // Table vectors, back-to-back: each start is issued in the previous pulse cycle
        for (int i = 0; i < 6; i++) begin
            do_op(0, vecs[i].op, vecs[i].a, vecs[i].b, 4, $sformatf("vec%0d", i), vecs[i].scr);
            check($sformatf("vec%0d table", i), res8, vecs[i].exp);
        end
        step();
        check("pulse one cycle", {31'd0, rdy8}, 32'd0);
        check("held after pulse", res8, 32'hA5A5A5A5);

        // Reset during an XOR after two BUSY edges
        opcode = 2'd2;
        opa    = 32'hDEADBEEF;
        opb    = 32'h0F0F0F0F;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        repeat (2) step();
        #2 reset = 1'b1;
        #1;
        check("abort result", res8, 32'd0);
        check("abort rdy_busy", {30'd0, rdy8, busy8}, 32'd0);
        step();
        reset = 1'b0;
        seen  = 1'b0;
        repeat (6) begin
            step();
            if (rdy8 !== 1'b0 || busy8 !== 1'b0) seen = 1'b1;
        end
        check("no pulse after abort", {31'd0, seen}, 32'd0);
        do_op(0, 2'd2, 32'hDEADBEEF, 32'h0F0F0F0F, 4, "after abort", 1'b0);

        // Extreme slicings
        do_op(1, 2'd0, 32'hFFFFFFFF, 32'hA5A5A5A5, 1, "slice32", 1'b0);
        do_op(2, 2'd0, 32'hFFFFFFFF, 32'hA5A5A5A5, 32, "slice1", 1'b0);

        // Randomized ops on all three instances
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 2'($urandom_range(0, 3));
            w   = (i < 30) ? 0 : ((i < 35) ? 1 : 2);
            lat = (w == 0) ? 4 : ((w == 1) ? 1 : 32);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
            do_op(w, rop, ra, rb, lat, $sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
